// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory store buffer: default depth,
// word-index width, the buffered entry layout and the byte-lane merge
// used by both the drain and the load-forwarding paths.
package mem_pkg;

  localparam int SB_DEPTH = 4;
  localparam int WORD_W   = 10;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [31:0]       data;
    logic [3:0]        be;
    logic [31:0]       pc;
  } sb_entry_t;

  // Replace each enabled byte lane of base with the matching lane of data.
  function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Store-to-load forwarding network: overlays every valid buffered store to
// the requested word on top of the DM read data, oldest first, so the
// youngest store owns each byte it enables.
module sb_fwd_merge
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  validMask,
  input  logic [PTR_W-1:0]  head,
  input  logic [WORD_W-1:0] ldWord,
  input  logic [31:0]       baseWord,
  output logic [31:0]       mergedWord
);

  logic [PTR_W-1:0] idx;

  // Walk from head (oldest) towards tail (youngest); later merges overwrite earlier ones.
  always_comb begin
    mergedWord = baseWord;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (validMask[idx] && (entries[idx].word == ldWord)) begin
        mergedWord = byte_merge(mergedWord, entries[idx].data, entries[idx].be);
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store buffer between the MEM stage and the word-addressed data
// memory. Stores are queued and retired one per cycle with a read-merge-write
// whenever the DM port is free; loads see buffered bytes via forwarding.
//
// Handshake: st_valid / ld_valid are requests and ~stall is their ready.
// A store is taken on an edge where st_valid & ~stall; a load completes
// combinationally in any cycle where ld_valid & ~stall. A stalled request
// must be held and re-presented the next cycle.
module dm_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_pc,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        empty,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic [31:0] MemPC,
  input  logic [31:0] MemRdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t         entries [DEPTH];
  sb_entry_t         headEntry;
  logic [PTR_W-1:0]  head, tail, offs;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  validMask;
  logic              full, doPush, doDrain, doLoad;
  logic [WORD_W-1:0] ldWord;
  logic [31:0]       fwdWord;

  assign full      = (count == CNT_W'(DEPTH));
  assign ldWord    = ld_addr[11:2];
  assign headEntry = entries[head];
  // A full buffer always drains, even over a pending load, so the pipeline can progress.
  assign doPush    = st_valid & ~full;
  assign doDrain   = (count != '0) & (~ld_valid | full);
  assign doLoad    = ld_valid & ~full;
  assign stall     = ~reset & (st_valid | ld_valid) & full;
  assign empty     = reset | (count == '0);

  // Entry i is live when its distance from head is below the occupancy count.
  always_comb begin
    validMask = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs         = PTR_W'(i) - head;
      validMask[i] = ({1'b0, offs} < count);
    end
  end

  // FIFO pointers, occupancy and entry storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        entries[tail] <= '{word: st_addr[11:2], data: st_data, be: st_be, pc: st_pc};
        tail          <= tail + PTR_W'(1);
      end
      if (doDrain) head <= head + PTR_W'(1);
      case ({doPush, doDrain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  sb_fwd_merge #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
    .entries   (entries),
    .validMask (validMask),
    .head      (head),
    .ldWord    (ldWord),
    .baseWord  (MemRdata),
    .mergedWord(fwdWord)
  );

  // DM port mux: drain owns the port when granted, otherwise an unstalled load reads.
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemAddr  = '0;
    MemData  = '0;
    MemPC    = '0;
    ld_data  = '0;
    if (!reset) begin
      if (doDrain) begin
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        MemAddr  = {20'b0, headEntry.word, 2'b00};
        MemData  = byte_merge(MemRdata, headEntry.data, headEntry.be);
        MemPC    = headEntry.pc;
      end else if (doLoad) begin
        MemRead  = 1'b1;
        MemAddr  = {20'b0, ldWord, 2'b00};
        ld_data  = fwdWord;
      end
    end
  end

endmodule
